traffic_light_monitor: RTL

Receive-side checker for the red/yellow/green light outputs of the traffic light controller. It synchronises and deglitches the three light lines, decodes them into a phase, and measures each phase's dwell in controller time-base ticks. It flags illegal light patterns, out-of-order phase transitions and dwell-time violations, and counts completed cycles. It sits in the core-clock domain beside the controller and feeds status to the debug/bidirectional outputs.

---
 rtl/traffic_light_monitor_if.sv | 29 ++
 rtl/traffic_light_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor_if.sv
// Light-line, time-base and status bundle between the traffic light
// controller side (master) and the light monitor (slave).
interface traffic_light_monitor_if;
   logic       light_r;
   logic       light_y;
   logic       light_g;
   logic       tick;
   logic       clr_err;
   logic [2:0] phase;
   logic       phase_chg;
   logic [7:0] dwell;
   logic [7:0] cycles;
   logic       err_seq;
   logic       err_time;
   logic       err_illegal;
   logic       err_any;

   modport master (
      output light_r, light_y, light_g, tick, clr_err,
      input  phase, phase_chg, dwell, cycles,
      input  err_seq, err_time, err_illegal, err_any
   );

   modport slave (
      input  light_r, light_y, light_g, tick, clr_err,
      output phase, phase_chg, dwell, cycles,
      output err_seq, err_time, err_illegal, err_any
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic light outputs: synchronises and
// debounces {r,y,g}, decodes the phase, times each phase in controller ticks
// and raises sticky sequence / timing / illegal-pattern flags.
module traffic_light_monitor #(
   parameter int T_RED   = 31,
   parameter int T_RY    = 3,
   parameter int T_GREEN = 20,
   parameter int T_YEL   = 3,
   parameter int TOL     = 1,
   parameter int DEB     = 2
) (
   input logic                    clk,
   input logic                    rst,
   traffic_light_monitor_if.slave bus
);

   typedef enum logic [2:0] {
      PH_OFF   = 3'd0,
      PH_RED   = 3'd1,
      PH_RY    = 3'd2,
      PH_GREEN = 3'd3,
      PH_YEL   = 3'd4,
      PH_ILL   = 3'd7
   } phase_t;

   localparam logic [3:0] DEB_M1 = 4'(DEB - 1);

   function automatic phase_t decode_pat(input logic [2:0] pat);
      case (pat)
         3'b000:  return PH_OFF;
         3'b100:  return PH_RED;
         3'b110:  return PH_RY;
         3'b001:  return PH_GREEN;
         3'b010:  return PH_YEL;
         default: return PH_ILL;
      endcase
   endfunction

   function automatic int nominal_dwell(input phase_t ph);
      case (ph)
         PH_RED:   return T_RED;
         PH_RY:    return T_RY;
         PH_GREEN: return T_GREEN;
         PH_YEL:   return T_YEL;
         default:  return 0;
      endcase
   endfunction

   // Registers
   logic [2:0] r_sync1, r_sync2, r_cand, r_acc;
   logic [3:0] r_stab;
   phase_t     r_phase;
   logic       r_phase_chg;
   logic [7:0] r_dwell, r_cycles;
   logic       r_err_seq, r_err_time, r_err_ill;
   logic       r_skip;   // current RED followed OFF: its dwell is not checked
   logic       r_over;   // overstay already flagged in the current phase

   // Next-state and decode wires
   logic [3:0] w_stab_nxt;
   logic [2:0] w_acc_nxt;
   phase_t     w_phase_nxt, w_new;
   logic [7:0] w_dwell_nxt, w_cycles_nxt;
   logic       w_skip_nxt, w_over_nxt;
   logic       w_accept, w_legal, w_timed;
   logic       w_set_seq, w_set_time, w_set_ill;
   logic       w_err_seq_nxt, w_err_time_nxt, w_err_ill_nxt;
   int         w_lo, w_hi, w_dwell_int;

   // State register: synchroniser, debounce candidate and all monitor state.
   always_ff @(posedge clk) begin
      // NOTE: every flop here is a small control register, so all of them are
      // reset; sequential state is assigned only with non-blocking <= so the
      // two synchroniser stages really form a two-flop chain.
      if (rst) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_cand      <= '0;
         r_stab      <= '0;
         r_acc       <= '0;
         r_phase     <= PH_OFF;
         r_phase_chg <= 1'b0;
         r_dwell     <= '0;
         r_cycles    <= '0;
         r_err_seq   <= 1'b0;
         r_err_time  <= 1'b0;
         r_err_ill   <= 1'b0;
         r_skip      <= 1'b0;
         r_over      <= 1'b0;
      end else begin
         r_sync1     <= {bus.light_r, bus.light_y, bus.light_g};
         r_sync2     <= r_sync1;
         r_cand      <= r_sync2;
         r_stab      <= w_stab_nxt;
         r_acc       <= w_acc_nxt;
         r_phase     <= w_phase_nxt;
         r_phase_chg <= w_accept;
         r_dwell     <= w_dwell_nxt;
         r_cycles    <= w_cycles_nxt;
         r_err_seq   <= w_err_seq_nxt;
         r_err_time  <= w_err_time_nxt;
         r_err_ill   <= w_err_ill_nxt;
         r_skip      <= w_skip_nxt;
         r_over      <= w_over_nxt;
      end
   end

   // Next state: debounce/accept, transition and dwell checks, counters, flags.
   always_comb begin
      // NOTE: defaults first, so no branch leaves a signal unassigned (no latch).
      w_stab_nxt   = r_stab;
      w_acc_nxt    = r_acc;
      w_phase_nxt  = r_phase;
      w_dwell_nxt  = r_dwell;
      w_cycles_nxt = r_cycles;
      w_skip_nxt   = r_skip;
      w_over_nxt   = r_over;
      w_set_seq    = 1'b0;
      w_set_time   = 1'b0;
      w_set_ill    = 1'b0;
      w_new        = decode_pat(r_sync2);
      w_lo         = nominal_dwell(r_phase) - TOL;
      w_hi         = nominal_dwell(r_phase) + TOL;
      w_dwell_int  = int'(r_dwell);
      w_timed      = (r_phase inside {PH_RED, PH_RY, PH_GREEN, PH_YEL}) && !r_skip;

      // Stability counter restarts whenever the synchronised pattern moves.
      if (r_sync2 != r_cand) begin
         w_stab_nxt = '0;
      end else if (r_stab != 4'hF) begin
         w_stab_nxt = r_stab + 4'd1;
      end
      w_accept = (w_stab_nxt == DEB_M1) && (r_sync2 != r_acc);

      w_legal = (w_new == PH_OFF)
             || (r_phase == PH_OFF   && w_new == PH_RED)
             || (r_phase == PH_RED   && w_new == PH_RY)
             || (r_phase == PH_RY    && w_new == PH_GREEN)
             || (r_phase == PH_GREEN && w_new == PH_YEL)
             || (r_phase == PH_YEL   && w_new == PH_RED);

      if (w_accept) begin
         // A tick on the accept edge is dropped: the new phase starts at 0.
         w_acc_nxt   = r_sync2;
         w_phase_nxt = w_new;
         w_dwell_nxt = '0;
         w_over_nxt  = 1'b0;
         w_skip_nxt  = (r_phase == PH_OFF) && (w_new == PH_RED);
         if (w_new == PH_ILL) begin
            w_set_ill = 1'b1;
         end else if (!w_legal) begin
            w_set_seq = 1'b1;
         end
         if (w_timed && !r_over && (w_new != PH_OFF) &&
             ((w_dwell_int < w_lo) || (w_dwell_int > w_hi))) begin
            w_set_time = 1'b1;
         end
         if (r_phase == PH_YEL && w_new == PH_RED) begin
            w_cycles_nxt = r_cycles + 8'd1;
         end
      end else if (bus.tick) begin
         if (r_dwell != 8'hFF) begin
            w_dwell_nxt = r_dwell + 8'd1;
         end
         // Overstay fires on the tick that takes dwell to T+TOL+1.
         if (w_timed && !r_over && (w_dwell_int == w_hi)) begin
            w_set_time = 1'b1;
            w_over_nxt = 1'b1;
         end
      end

      // A new error beats a simultaneous clear.
      w_err_seq_nxt  = w_set_seq  | (r_err_seq  & ~bus.clr_err);
      w_err_time_nxt = w_set_time | (r_err_time & ~bus.clr_err);
      w_err_ill_nxt  = w_set_ill  | (r_err_ill  & ~bus.clr_err);
   end

   assign bus.phase       = r_phase;
   assign bus.phase_chg   = r_phase_chg;
   assign bus.dwell       = r_dwell;
   assign bus.cycles      = r_cycles;
   assign bus.err_seq     = r_err_seq;
   assign bus.err_time    = r_err_time;
   assign bus.err_illegal = r_err_ill;
   assign bus.err_any     = r_err_seq | r_err_time | r_err_ill;

endmodule
